// File: rtl/uart_pack.sv
// Shared UART constants and receiver state encoding; UART_RX_PARITY_EN adds the PARITY state.
package uart_pack;

  localparam int br_cnt_max  = 15;
  localparam int br2_cnt_max = 7;
  localparam int br_cnt_w    = $clog2(br_cnt_max + 1);
  localparam int rx_data_w   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } rx_state_t;

endpackage

// File: rtl/as_br.sv
// Baud-rate generator: free-running bit counter, br_o at bit end, br2_o at mid-bit.
// start_i realigns the counter so it reads 0 on the following cycle.
module as_br
  import uart_pack::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic br_o,
  output logic br2_o
);

  logic [br_cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (start_i || cnt_q == br_cnt_w'(br_cnt_max)) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign br_o  = (cnt_q == br_cnt_w'(br_cnt_max));
  assign br2_o = (cnt_q == br_cnt_w'(br2_cnt_max));

endmodule

// File: rtl/as_sync.sv
// Generic 2-flop synchroniser; RST_VAL sets the value both flops take in reset.
module as_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/as_rx.sv
// UART receiver: start-edge detect, mid-bit sampling via as_br br2, LSB-first deserialise.
// UART_RX_PARITY_EN adds an even-parity bit; outputs are registered one cycle after the stop sample.
module as_rx
  import uart_pack::*;
#(
  parameter int DATA_W = rx_data_w
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  input  logic              br2_i,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_err_o,
  output logic              parity_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_t         state_q, state_d;
  logic              rx_s, rx_prev_q, fall;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic              start_q, start_d, valid_q, valid_d, ferr_q, ferr_d;
  logic              par_ok;

  as_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign fall = rx_prev_q & ~rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign par_ok       = ~(^sh_q ^ par_q);
  assign parity_err_o = perr_q;
`else
  assign par_ok       = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    start_d = 1'b0;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      // start_o pulses while still IDLE; the move to START follows it so busy_o lags by one cycle
      S_IDLE: begin
        if (start_q)   state_d = S_START;
        else if (fall) start_d = 1'b1;
      end
      S_START: if (br2_i) begin
        cnt_d   = '0;
        state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (br2_i) begin
        sh_d  = {rx_s, sh_q[DATA_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (br2_i) begin
        par_d   = rx_s;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (br2_i) begin
        if (rx_s) begin
          state_d = S_IDLE;
          if (par_ok) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else perr_d = 1'b1;
`endif
        end else begin
          ferr_d  = 1'b1;
          state_d = S_BREAK;
        end
      end
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_s;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign start_o     = start_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_as_rx.sv
// Bench for as_br + as_rx: directed serial frames, expected results queued and checked by a monitor.
`timescale 1ns/1ps
module tb_as_rx;
  import uart_pack::*;

  localparam int BIT = br_cnt_max + 1;
  localparam logic [2:0] K_VLD = 3'b001;
  localparam logic [2:0] K_FER = 3'b010;
  localparam logic [2:0] K_PER = 3'b100;

  logic       clk = 1'b0;
  logic       rst, rx, br_o, br2, start, valid, ferr, perr, busy;
  logic [7:0] data;

  always #5 clk = ~clk;

  as_br u_br (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .br_o    (br_o),
    .br2_o   (br2)
  );

  as_rx #(.DATA_W(rx_data_w)) u_rx (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .br2_i        (br2),
    .start_o      (start),
    .data_o       (data),
    .valid_o      (valid),
    .frame_err_o  (ferr),
    .parity_err_o (perr),
    .busy_o       (busy)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         starts = 0;
  logic [2:0] exp_kind_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] last_good;
  logic [2:0] mon_flags, mon_kind;
  logic [7:0] mon_data;
  int         s0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && start) starts++;
    mon_flags = {perr, ferr, valid};
    if (mon_flags != 3'b000) begin
      if (exp_kind_q.size() == 0) begin
        check("unexpected_flags", 32'(mon_flags), 32'd0);
      end else begin
        mon_kind = exp_kind_q.pop_front();
        mon_data = exp_data_q.pop_front();
        check("result_flags", 32'(mon_flags), 32'(mon_kind));
        check("result_data", 32'(data), 32'(mon_data));
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input bit bad_par);
    if (!stop_lvl) begin
      exp_kind_q.push_back(K_FER);
      exp_data_q.push_back(last_good);
    end else if (bad_par) begin
      exp_kind_q.push_back(K_PER);
      exp_data_q.push_back(last_good);
    end else begin
      exp_kind_q.push_back(K_VLD);
      exp_data_q.push_back(d);
      last_good = d;
    end
    hold(1'b0, BIT);
    for (int i = 0; i < rx_data_w; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ bad_par, BIT);
`endif
    hold(stop_lvl, BIT);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_ferr"}, 32'(ferr), 32'd0);
    check({tag, "_perr"}, 32'(perr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
  endtask

  initial begin
    last_good = 8'h00;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    hold(1'b1, BIT);

    send_frame(8'h55, 1'b1, 1'b0);
    hold(1'b1, BIT);

    // back-to-back: no idle gap between stop bit and next start bit
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    hold(1'b1, 2 * BIT);

    s0 = starts;
    hold(1'b0, 4);
    hold(1'b1, 3 * BIT);
    check("glitch_start_pulses", 32'(starts - s0), 32'd1);
    check("glitch_busy", 32'(busy), 32'd0);

    s0 = starts;
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 2 * BIT);
    check("break_busy_low_line", 32'(busy), 32'd1);
    hold(1'b1, BIT);
    check("break_busy_released", 32'(busy), 32'd0);
    check("break_no_retrigger", 32'(starts - s0), 32'd1);
    check("break_data_kept", 32'(data), 32'h0F);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, BIT);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, BIT);
`endif

    // reset in the middle of data bit 4 of 0xFF
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT);
    hold(1'b1, BIT / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    check_reset_outputs("midreset");
    hold(1'b1, 6 * BIT);
    check("midreset_idle", 32'(busy), 32'd0);

    send_frame(8'h81, 1'b1, 1'b0);
    hold(1'b1, 2 * BIT);
    check("final_data", 32'(data), 32'h81);
    check("pending_results", 32'(exp_kind_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/as_rx.md
# as_rx

UART receive stage sitting directly downstream of the baud-rate generator `as_br`. It synchronises the serial line, detects a start bit and restarts `as_br` through its `start_i` input. It then samples each bit on the mid-bit strobe `br2_o`, deserialises one frame LSB-first and presents the received byte with a one-cycle valid pulse and error flags. One `as_rx` instance pairs with one `as_br` instance.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame; legal range 5..9.

Ports:
- `clk_i` input 1: system clock. One clock domain; reset is synchronous and active-high.
- `rst_i` input 1: synchronous active-high reset.
- `rx_i` input 1: asynchronous serial line; idle level is high.
- `br2_i` input 1: mid-bit strobe, connected to `as_br.br2_o`.
- `start_o` output 1: one-cycle pulse to `as_br.start_i`; it realigns the baud counter to the start-bit edge.
- `data_o` output DATA_W: last good byte; holds its value until the next good frame.
- `valid_o` output 1: one-cycle pulse when `data_o` updates.
- `frame_err_o` output 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err_o` output 1: one-cycle pulse on parity mismatch. Tied to 0 when parity is compiled out.
- `busy_o` output 1: high in every state except IDLE.

## Operation
- `rx_i` passes through a 2-flop synchroniser (`rx_s`). The synchroniser flops reset to 1.
- Edge detect: a falling edge is `rx_s` equal to 0 while the previous `rx_s` equals 1.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: on a falling edge, pulse `start_o` in that same cycle and go to START.
- START: on `br2_i`:
  - if `rx_s` is 0, clear the bit counter and go to DATA;
  - otherwise this is a glitch: return to IDLE with no output.
- DATA: on each `br2_i`, shift `rx_s` into the MSB of the shift register (right shift, so data is LSB-first) and increment the bit counter. After DATA_W samples, go to PARITY if enabled, otherwise STOP.
- PARITY: on `br2_i`, store the parity bit and go to STOP.
- STOP, on `br2_i`, stop bit high:
  - parity OK (or parity compiled out): load `data_o` and pulse `valid_o`;
  - parity mismatch: pulse `parity_err_o` and leave `data_o` unchanged.
  - Then go to IDLE.
- STOP, on `br2_i`, stop bit low: pulse `frame_err_o`, leave `data_o` unchanged, go to BREAK.
- BREAK: wait until `rx_s` is 1, then go to IDLE. This prevents a held-low line from retriggering.
- Only `br2_i` is consumed. `br_o` of `as_br` is not used by this block.
- Reset mid-frame: everything returns to reset values on the next edge and no partial byte is emitted.
- Any `br2_i` pulse that arrives in IDLE or BREAK is ignored.

## Timing
- Reset values: `data_o` 0, `valid_o` 0, `frame_err_o` 0, `parity_err_o` 0, `busy_o` 0, `start_o` 0, state IDLE.
- Line to detect: a falling edge on `rx_i` produces `start_o` 2–3 cycles later (synchroniser plus edge register).
- `start_o` is registered and lasts exactly one cycle. `as_br` sees its counter at 0 on the following cycle, so the first `br2_i` lands about half a bit period after the edge.
- `valid_o`, `frame_err_o` and `parity_err_o` are registered. They assert one cycle after the stop-bit `br2_i` and are mutually exclusive.
- `data_o` changes in the same cycle that `valid_o` is high.
- Back-to-back frames: IDLE is re-entered in the same cycle the result flags assert, so a start edge half a bit after the stop sample is accepted.
- `busy_o` rises the cycle after `start_o` and falls on the cycle the block enters IDLE.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: the PARITY state exists; one even-parity bit follows the data bits; `parity_err_o` is live.
- Undefined: the frame is start, DATA_W data bits, stop; PARITY state and parity logic are absent; `parity_err_o` is constant 0.

## Structure
- Package `uart_pack`:
  - holds the state enum `rx_state_t`;
  - already holds `br_cnt_max` and `br2_cnt_max`, which are used by the bench to compute bit period;
  - add `rx_data_w` as the default for DATA_W.
- Sub-module `as_sync`: generic 2-flop synchroniser with a reset value parameter. `as_rx` instantiates it once.
- Bench instantiates `as_br` and `as_rx` together, with `as_rx.start_o` driving `as_br.start_i`.

## Test plan
- Frame 0x55, correct stop bit -> single `valid_o` pulse with `data_o` = 0x55; both error flags stay 0.
- Two back-to-back frames 0xA3 then 0x0F with no idle gap -> two `valid_o` pulses, `data_o` 0xA3 then 0x0F.
- Low glitch on `rx_i` shorter than br2_cnt_max cycles -> `start_o` pulses, the block returns to IDLE, and there is no `valid_o` or error pulse.
- Frame 0x3C with stop bit low, line held low 3 bit times -> one `frame_err_o` pulse, `data_o` unchanged, `busy_o` high until the line returns high, with no retrigger.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 -> `parity_err_o` pulse and `data_o` unchanged; 0x07 with parity bit 1 -> `valid_o` with `data_o` = 0x07.
- Assert `rst_i` for 1 cycle during data bit 4 of 0xFF -> all outputs return to reset values and no `valid_o` pulse; the next full frame 0x81 is received correctly.
